// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Results are handed to a consumer through a valid/ack handshake with overrun detection.
module period_meter #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  input  logic             period_ack,
  output logic             overrun,
  output logic             no_sig
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   rise_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       hcnt_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // rise is registered so the measurement runs one cycle behind s; s_d is the
  // level aligned with rise_q, so the rise cycle itself always counts as high.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
      rise_q <= rise;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      no_sig       <= 1'b0;
    end else begin
      if (period_ack && period_valid) begin
        period_valid <= 1'b0;
        overrun      <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (rise_q) begin
            state_q <= StMeasure;
            cnt_q   <= CntOne;
            hcnt_q  <= CntOne;
            no_sig  <= 1'b0;
          end
        end
        StMeasure: begin
          if (rise_q) begin
            period_out   <= cnt_q;
            high_out     <= hcnt_q;
            period_valid <= 1'b1;
            // A capture coinciding with ack means the old result was consumed.
            if (period_valid && !period_ack) begin
              overrun <= 1'b1;
            end
            cnt_q  <= CntOne;
            hcnt_q <= CntOne;
          end else if (cnt_q == CntMax) begin
            no_sig  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntOne;
            if (s_d) begin
              hcnt_q <= hcnt_q + CntOne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: table of square waves plus hand-written
// sequences for arming, overrun, ack-on-capture, timeout and mid-period clear.
module tb_period_meter;

  localparam int unsigned W  = 8;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         sig_in;
  logic         period_ack;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         period_valid;
  logic         overrun;
  logic         no_sig;

  int n_pass  = 0;
  int n_total = 0;

  period_meter #(
    .CNT_W      (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .period_valid(period_valid),
    .period_ack  (period_ack),
    .overrun     (overrun),
    .no_sig      (no_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    int exp_p;
    int exp_h;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // One clk cycle: inputs change on the falling edge, away from the sampling edge.
  task automatic step(input logic s, input logic a);
    @(negedge clk);
    sig_in     = s;
    period_ack = a;
  endtask

  task automatic run_wave(input int p, input int h, input int n, input int ph0,
                          input int ack_at);
    for (int i = 0; i < n; i++) step(((ph0 + i) % p) < h, i == ack_at);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    clr        = 1'b1;
    sig_in     = 1'b0;
    period_ack = 1'b0;
    #1;
    chk({tag, " clr period_out"}, 32'(period_out), 0);
    chk({tag, " clr high_out"}, 32'(high_out), 0);
    chk({tag, " clr valid"}, 32'(period_valid), 0);
    chk({tag, " clr overrun"}, 32'(overrun), 0);
    chk({tag, " clr no_sig"}, 32'(no_sig), 0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{p: 10,  h: 5,   exp_p: 10,  exp_h: 5};
    vecs[1] = '{p: 6,   h: 2,   exp_p: 6,   exp_h: 2};
    vecs[2] = '{p: 2,   h: 1,   exp_p: 2,   exp_h: 1};
    vecs[3] = '{p: 7,   h: 1,   exp_p: 7,   exp_h: 1};
    vecs[4] = '{p: 20,  h: 19,  exp_p: 20,  exp_h: 19};
    vecs[5] = '{p: 254, h: 100, exp_p: 254, exp_h: 100};

    clr        = 1'b1;
    sig_in     = 1'b0;
    period_ack = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Table: several captures without ack, then drain, check, and one ack.
    for (int i = 0; i < 6; i++) begin
      do_clr($sformatf("v%0d", i));
      run_wave(vecs[i].p, vecs[i].h, 2 * vecs[i].p + 6, 0, -1);
      repeat (6) step(1'b0, 1'b0);
      chk($sformatf("v%0d valid", i), 32'(period_valid), 1);
      chk($sformatf("v%0d period", i), 32'(period_out), 32'(vecs[i].exp_p));
      chk($sformatf("v%0d high", i), 32'(high_out), 32'(vecs[i].exp_h));
      chk($sformatf("v%0d overrun", i), 32'(overrun), 1);
      chk($sformatf("v%0d no_sig", i), 32'(no_sig), 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk($sformatf("v%0d acked valid", i), 32'(period_valid), 0);
      chk($sformatf("v%0d acked overrun", i), 32'(overrun), 0);
    end

    // First rise only arms; second gives the result; ack clears it.
    do_clr("t1");
    run_wave(10, 5, 10, 0, -1);
    chk("t1 arm valid", 32'(period_valid), 0);
    run_wave(10, 5, 7, 10, -1);
    chk("t1 valid", 32'(period_valid), 1);
    chk("t1 period", 32'(period_out), 10);
    chk("t1 high", 32'(high_out), 5);
    chk("t1 overrun", 32'(overrun), 0);
    run_wave(10, 5, 4, 17, 0);
    chk("t1 ack valid", 32'(period_valid), 0);
    chk("t1 ack overrun", 32'(overrun), 0);

    // No ack for three periods -> overrun; a single ack clears both flags.
    run_wave(10, 5, 30, 21, -1);
    chk("t2 valid", 32'(period_valid), 1);
    chk("t2 overrun", 32'(overrun), 1);
    chk("t2 period", 32'(period_out), 10);
    chk("t2 high", 32'(high_out), 5);
    run_wave(10, 5, 3, 51, 0);
    chk("t2 ack valid", 32'(period_valid), 0);
    chk("t2 ack overrun", 32'(overrun), 0);

    // Overwrite sets overrun; an ack landing on the capture cycle clears it.
    do_clr("t3");
    run_wave(10, 5, 20, 0, -1);
    chk("t3 first period", 32'(period_out), 10);
    run_wave(8, 3, 5, 0, -1);
    chk("t3 ovw valid", 32'(period_valid), 1);
    chk("t3 ovw overrun", 32'(overrun), 1);
    chk("t3 ovw period", 32'(period_out), 10);
    chk("t3 ovw high", 32'(high_out), 5);
    run_wave(8, 3, 8, 5, 6);
    chk("t3 cap+ack valid", 32'(period_valid), 1);
    chk("t3 cap+ack overrun", 32'(overrun), 0);
    chk("t3 cap+ack period", 32'(period_out), 8);
    chk("t3 cap+ack high", 32'(high_out), 3);

    // Timeout after exactly 255 cycles of silence following the arming rise.
    do_clr("t4");
    step(1'b1, 1'b0);
    repeat (258) step(1'b0, 1'b0);
    chk("t4 no_sig early", 32'(no_sig), 0);
    step(1'b0, 1'b0);
    chk("t4 no_sig", 32'(no_sig), 1);
    chk("t4 valid", 32'(period_valid), 0);
    run_wave(20, 7, 23, 0, -1);
    chk("t4 rearm no_sig", 32'(no_sig), 0);
    chk("t4 rearm valid", 32'(period_valid), 0);
    run_wave(20, 7, 3, 23, -1);
    chk("t4 valid2", 32'(period_valid), 1);
    chk("t4 period", 32'(period_out), 20);
    chk("t4 high", 32'(high_out), 7);

    // Clear mid-period discards the pending result; meter re-arms afterwards.
    do_clr("t5a");
    run_wave(6, 2, 15, 0, -1);
    chk("t5 pre valid", 32'(period_valid), 1);
    do_clr("t5 mid");
    run_wave(6, 2, 9, 0, -1);
    chk("t5 arm valid", 32'(period_valid), 0);
    run_wave(6, 2, 3, 9, -1);
    chk("t5 valid", 32'(period_valid), 1);
    chk("t5 period", 32'(period_out), 6);
    chk("t5 high", 32'(high_out), 2);
    chk("t5 overrun", 32'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
